// File: rtl/lcd_pkg.sv
// Shared types, command bytes and default timing for the LCD frame writer.
package lcd_pkg;

   localparam int DEF_POWERUP_CYC    = 2_000_000;
   localparam int DEF_E_PULSE_CYC    = 50;
   localparam int DEF_CMD_WAIT_CYC   = 5_000;
   localparam int DEF_CLEAR_WAIT_CYC = 200_000;

   localparam logic [7:0] CMD_FUNC_SET = 8'h38;
   localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
   localparam logic [7:0] CMD_ENTRY    = 8'h06;
   localparam logic [7:0] CMD_CLEAR    = 8'h01;
   localparam logic [7:0] CMD_ROW0     = 8'h80;
   localparam logic [7:0] CMD_ROW1     = 8'hC0;

   typedef enum logic [2:0] {
      ST_POWERUP,
      ST_INIT,
      ST_IDLE,
      ST_ADDR1,
      ST_ROW1,
      ST_ADDR2,
      ST_ROW2
   } lcd_state_e;

   typedef enum logic [1:0] {
      PH_IDLE,
      PH_SETUP,
      PH_PULSE,
      PH_WAIT
   } wr_phase_e;

   // Initialisation command sequence, indexed 0..3.
   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      logic [7:0] cmd;
      case (idx)
         2'd0:    cmd = CMD_FUNC_SET;
         2'd1:    cmd = CMD_DISP_ON;
         2'd2:    cmd = CMD_ENTRY;
         default: cmd = CMD_CLEAR;
      endcase
      return cmd;
   endfunction

   // Column 0 lives in [127:120]; column c starts at bit 8*(15-c).
   function automatic logic [7:0] line_char(input logic [127:0] line, input logic [3:0] col);
      return line[{~col, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/lcd_frame_writer_if.sv
// Host-side text/refresh signals plus the parallel LCD bus.
interface lcd_frame_writer_if;
   logic [127:0] line1;
   logic [127:0] line2;
   logic         refresh;
   logic         ready;
   logic         lcd_rs;
   logic         lcd_rw;
   logic         lcd_e;
   logic [7:0]   lcd_data;

   modport master (
      output line1, line2, refresh,
      input  ready, lcd_rs, lcd_rw, lcd_e, lcd_data
   );

   modport slave (
      input  line1, line2, refresh,
      output ready, lcd_rs, lcd_rw, lcd_e, lcd_data
   );
endinterface

// File: rtl/lcd_byte_writer.sv
// One LCD write slot: setup cycle, enable pulse, then a post-strobe wait.
// A start coinciding with done chains the next slot with no idle gap.
module lcd_byte_writer
   import lcd_pkg::*;
#(
   parameter int E_PULSE_CYC    = DEF_E_PULSE_CYC,
   parameter int CMD_WAIT_CYC   = DEF_CMD_WAIT_CYC,
   parameter int CLEAR_WAIT_CYC = DEF_CLEAR_WAIT_CYC
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] wr_byte,
   input  logic       rs,
   input  logic       long_wait,
   output logic       done,
   output logic       lcd_e,
   output logic [7:0] lcd_data,
   output logic       lcd_rs
);

   wr_phase_e   phase_q, phase_d;
   logic [31:0] cnt_q, cnt_d;
   logic        long_q, long_d;
   logic        e_q, e_d;
   logic [7:0]  data_q, data_d;
   logic        rs_q, rs_d;

   assign done     = (phase_q == PH_WAIT) && (cnt_q == 32'd0);
   assign lcd_e    = e_q;
   assign lcd_data = data_q;
   assign lcd_rs   = rs_q;

   // Slot sequencing with down-counters per phase; start overrides to reload.
   always_comb begin
      phase_d = phase_q;
      cnt_d   = cnt_q;
      long_d  = long_q;
      e_d     = e_q;
      data_d  = data_q;
      rs_d    = rs_q;
      case (phase_q)
         PH_IDLE: ;
         PH_SETUP: begin
            phase_d = PH_PULSE;
            e_d     = 1'b1;
            cnt_d   = 32'(E_PULSE_CYC - 1);
         end
         PH_PULSE: begin
            if (cnt_q == 32'd0) begin
               phase_d = PH_WAIT;
               e_d     = 1'b0;
               cnt_d   = long_q ? 32'(CLEAR_WAIT_CYC - 1) : 32'(CMD_WAIT_CYC - 1);
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         PH_WAIT: begin
            if (cnt_q == 32'd0) phase_d = PH_IDLE;
            else                cnt_d   = cnt_q - 32'd1;
         end
         default: phase_d = PH_IDLE;
      endcase
      if (start) begin
         phase_d = PH_SETUP;
         cnt_d   = 32'd0;
         e_d     = 1'b0;
         data_d  = wr_byte;
         rs_d    = rs;
         long_d  = long_wait;
      end
   end

   // Slot registers; reset drops lcd_e immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q <= PH_IDLE;
         cnt_q   <= '0;
         long_q  <= 1'b0;
         e_q     <= 1'b0;
         data_q  <= '0;
         rs_q    <= 1'b0;
      end else begin
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         long_q  <= long_d;
         e_q     <= e_d;
         data_q  <= data_d;
         rs_q    <= rs_d;
      end
   end

endmodule

// File: rtl/lcd_frame_writer.sv
// Power-up, init and two-row frame sequencer for an HD44780-style LCD.
//
// state   | meaning
// POWERUP | wait POWERUP_CYC cycles, outputs low
// INIT    | write 0x38, 0x0C, 0x06, 0x01
// IDLE    | ready; refresh captures both lines
// ADDR1   | write row-0 address 0x80
// ROW1    | write 16 chars of line1 snapshot
// ADDR2   | write row-1 address 0xC0
// ROW2    | write 16 chars of line2 snapshot
module lcd_frame_writer
   import lcd_pkg::*;
#(
   parameter int POWERUP_CYC    = DEF_POWERUP_CYC,
   parameter int E_PULSE_CYC    = DEF_E_PULSE_CYC,
   parameter int CMD_WAIT_CYC   = DEF_CMD_WAIT_CYC,
   parameter int CLEAR_WAIT_CYC = DEF_CLEAR_WAIT_CYC
) (
   input  logic                clk,
   input  logic                reset,
   lcd_frame_writer_if.slave   bus
);

   lcd_state_e   state_q, state_d;
   logic [3:0]   idx_q, idx_d;
   logic [31:0]  pwr_q, pwr_d;
   logic [127:0] snap1_q, snap1_d;
   logic [127:0] snap2_q, snap2_d;
   logic         ready_q, ready_d;

   logic         wr_start;
   logic [7:0]   wr_byte;
   logic         wr_rs;
   logic         wr_long;
   logic         wr_done;
   logic         wr_e;
   logic [7:0]   wr_data;
   logic         wr_rs_out;

   // Only the clear command needs the long post-strobe wait.
   assign wr_long = !wr_rs && (wr_byte == CMD_CLEAR);

   lcd_byte_writer #(
      .E_PULSE_CYC    (E_PULSE_CYC),
      .CMD_WAIT_CYC   (CMD_WAIT_CYC),
      .CLEAR_WAIT_CYC (CLEAR_WAIT_CYC)
   ) u_writer (
      .clk       (clk),
      .rst       (reset),
      .start     (wr_start),
      .wr_byte   (wr_byte),
      .rs        (wr_rs),
      .long_wait (wr_long),
      .done      (wr_done),
      .lcd_e     (wr_e),
      .lcd_data  (wr_data),
      .lcd_rs    (wr_rs_out)
   );

   assign bus.ready    = ready_q;
   assign bus.lcd_e    = wr_e;
   assign bus.lcd_data = wr_data;
   assign bus.lcd_rs   = wr_rs_out;
   assign bus.lcd_rw   = 1'b0;

   // Next state; each slot's successor is launched on the edge its predecessor ends.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      pwr_d    = pwr_q;
      snap1_d  = snap1_q;
      snap2_d  = snap2_q;
      wr_start = 1'b0;
      wr_byte  = 8'h00;
      wr_rs    = 1'b0;
      case (state_q)
         ST_POWERUP: begin
            if (pwr_q == 32'(POWERUP_CYC - 1)) begin
               state_d  = ST_INIT;
               idx_d    = 4'd0;
               wr_start = 1'b1;
               wr_byte  = init_cmd(2'd0);
            end else begin
               pwr_d = pwr_q + 32'd1;
            end
         end
         ST_INIT: begin
            if (wr_done) begin
               if (idx_q == 4'd3) begin
                  state_d = ST_IDLE;
                  idx_d   = 4'd0;
               end else begin
                  idx_d    = idx_q + 4'd1;
                  wr_start = 1'b1;
                  wr_byte  = init_cmd(idx_q[1:0] + 2'd1);
               end
            end
         end
         ST_IDLE: begin
            if (bus.refresh) begin
               snap1_d  = bus.line1;
               snap2_d  = bus.line2;
               state_d  = ST_ADDR1;
               wr_start = 1'b1;
               wr_byte  = CMD_ROW0;
            end
         end
         ST_ADDR1: begin
            if (wr_done) begin
               state_d  = ST_ROW1;
               idx_d    = 4'd0;
               wr_start = 1'b1;
               wr_byte  = line_char(snap1_q, 4'd0);
               wr_rs    = 1'b1;
            end
         end
         ST_ROW1: begin
            if (wr_done) begin
               idx_d    = idx_q + 4'd1;
               wr_start = 1'b1;
               if (idx_q == 4'd15) begin
                  state_d = ST_ADDR2;
                  wr_byte = CMD_ROW1;
               end else begin
                  wr_byte = line_char(snap1_q, idx_q + 4'd1);
                  wr_rs   = 1'b1;
               end
            end
         end
         ST_ADDR2: begin
            if (wr_done) begin
               state_d  = ST_ROW2;
               idx_d    = 4'd0;
               wr_start = 1'b1;
               wr_byte  = line_char(snap2_q, 4'd0);
               wr_rs    = 1'b1;
            end
         end
         ST_ROW2: begin
            if (wr_done) begin
               idx_d = idx_q + 4'd1;
               if (idx_q == 4'd15) begin
                  state_d = ST_IDLE;
               end else begin
                  wr_start = 1'b1;
                  wr_byte  = line_char(snap2_q, idx_q + 4'd1);
                  wr_rs    = 1'b1;
               end
            end
         end
         default: state_d = ST_POWERUP;
      endcase
      ready_d = (state_d == ST_IDLE);
   end

   // Sequencer registers; reset returns to POWERUP with everything cleared.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_POWERUP;
         idx_q   <= '0;
         pwr_q   <= '0;
         snap1_q <= '0;
         snap2_q <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pwr_q   <= pwr_d;
         snap1_q <= snap1_d;
         snap2_q <= snap2_d;
         ready_q <= ready_d;
      end
   end

endmodule

// File: doc/lcd_frame_writer.md
LCD_FRAME_WRITER -- requirements
Module: lcd_frame_writer

Interface
REQ-001 SHALL have parameters, one per line:
- POWERUP_CYC, default 2_000_000, idle cycles after reset before the first command (20 ms at 100 MHz).
- E_PULSE_CYC, default 50, lcd_e high width in cycles.
- CMD_WAIT_CYC, default 5_000, post-strobe wait for normal bytes.
- CLEAR_WAIT_CYC, default 200_000, post-strobe wait for the clear command 0x01.
REQ-002 SHALL have ports, one per line:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high reset.
- line1  in  128  row 0 text, ASCII; [127:120] = column 0.
- line2  in  128  row 1 text, ASCII; [127:120] = column 0.
- refresh  in  1  request to redraw both rows.
- ready  out  1  initialised, idle, and able to accept refresh.
- lcd_rs  out  1  0 = command, 1 = character data.
- lcd_rw  out  1  read/write select; tied low (write only).
- lcd_e  out  1  enable strobe.
- lcd_data  out  8  8-bit data bus.

Function
REQ-003 SHALL write every byte as one write slot:
- 1 setup cycle: lcd_data and lcd_rs valid, lcd_e low.
- E_PULSE_CYC cycles with lcd_e high.
- WAIT cycles with lcd_e low, where WAIT is CLEAR_WAIT_CYC for 0x01 and CMD_WAIT_CYC otherwise.
- lcd_data and lcd_rs held stable for the whole slot.
REQ-004 SHALL use states POWERUP -> INIT -> IDLE -> ADDR1 -> ROW1 -> ADDR2 -> ROW2 -> IDLE.
REQ-005 POWERUP SHALL count POWERUP_CYC cycles with all outputs low, then enter INIT.
REQ-006 INIT SHALL issue the commands 0x38, 0x0C, 0x06, 0x01 in that order, then enter IDLE.
REQ-007 ready SHALL be 1 only in IDLE.
REQ-008 In IDLE with refresh=1 at a clock edge, the block SHALL capture line1 and line2 into internal snapshot registers and leave IDLE; ready SHALL be 0 from the following cycle.
REQ-009 refresh while not in IDLE SHALL be ignored, not queued.
REQ-010 refresh held high SHALL start a new frame on the first IDLE cycle.
REQ-011 A frame SHALL consist of 34 write slots, in order:
- ADDR1 writes command 0x80.
- ROW1 writes 16 characters from the line1 snapshot, with lcd_rs=1, from [127:120] down to [7:0].
- ADDR2 writes command 0xC0.
- ROW2 writes the line2 snapshot the same way.
REQ-012 Changes on line1 and line2 during a frame SHALL NOT affect the displayed data.
REQ-013 The character index SHALL be a 4-bit counter; wrap from 15 to 0 SHALL advance ROW1 -> ADDR2 and ROW2 -> IDLE.
REQ-014 ready SHALL reassert exactly 34*(1+E_PULSE_CYC+CMD_WAIT_CYC) cycles after the capture edge.
REQ-015 After reset release, ready SHALL first assert exactly POWERUP_CYC + 3*(1+E_PULSE_CYC+CMD_WAIT_CYC) + (1+E_PULSE_CYC+CLEAR_WAIT_CYC) cycles later.
REQ-016 lcd_rw SHALL be constant 0.
REQ-017 All outputs SHALL be registered (glitch-free).

Reset
REQ-018 While reset=1, all outputs SHALL be 0 and the state SHALL be POWERUP.
REQ-019 While reset=1, all counters and the snapshot registers SHALL be cleared.
REQ-020 Reset mid-frame or mid-strobe SHALL drop lcd_e immediately (asynchronously) and restart the full power-up and init sequence.

Structure
REQ-021 A shared package lcd_pkg SHALL hold:
- the state enum;
- command constants CMD_FUNC_SET=0x38, CMD_DISP_ON=0x0C, CMD_ENTRY=0x06, CMD_CLEAR=0x01, CMD_ROW0=0x80, CMD_ROW1=0xC0;
- the default timing parameters.
REQ-022 A single sub-module, lcd_byte_writer, SHALL implement one write slot:
- inputs: start, byte, rs, long_wait;
- outputs: done (1-cycle pulse at slot end), lcd_e, lcd_data, lcd_rs.

Verification
(All scenarios use POWERUP_CYC=20, E_PULSE_CYC=2, CMD_WAIT_CYC=4, CLEAR_WAIT_CYC=10; slot = 7 cycles, clear slot = 13 cycles.)
REQ-023 Power-up: release reset -> ready rises at cycle 54; lcd_data strobes 0x38, 0x0C, 0x06, 0x01 with rs=0, each with lcd_e high for 2 cycles.
REQ-024 Frame: line1="Morse Translator", line2="  LCD Test OK   ", 1-cycle refresh -> 34 strobes captured as 0x80, "Morse Translator" (rs=1), 0xC0, line2 bytes; ready returns 238 cycles after capture.
REQ-025 Busy request: pulse refresh during ROW1 -> no extra frame; exactly 34 strobes total.
REQ-026 Snapshot: change line1 to all 0x41 mid-ROW1 -> original bytes still written.
REQ-027 Held refresh for 10 cycles from the first ready -> exactly one frame, since refresh has dropped before ready returns.
REQ-028 Mid-frame reset during lcd_e high -> lcd_e=0 within the same cycle; the sequence restarts and ready rises 54 cycles after release.
